// File: rtl/axi_rd_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axi_rd_arbiter: two-master round-robin arbiter for the AXI AR/R channels. Rev 1.0
// ---------------------------------------------------------------------------
module axi_rd_arbiter #(
  parameter int NUM_M          = 2,
  parameter bit LAST_GRANT_RST = 1'b1
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  // master 0
  input  logic [3:0]  M0_ARID,
  input  logic [31:0] M0_ARADDR,
  input  logic [3:0]  M0_ARLEN,
  input  logic [2:0]  M0_ARSIZE,
  input  logic [1:0]  M0_ARBURST,
  input  logic        M0_ARVALID,
  output logic        M0_ARREADY,
  output logic [3:0]  M0_RID,
  output logic [31:0] M0_RDATA,
  output logic [1:0]  M0_RRESP,
  output logic        M0_RLAST,
  output logic        M0_RVALID,
  input  logic        M0_RREADY,
  // master 1
  input  logic [3:0]  M1_ARID,
  input  logic [31:0] M1_ARADDR,
  input  logic [3:0]  M1_ARLEN,
  input  logic [2:0]  M1_ARSIZE,
  input  logic [1:0]  M1_ARBURST,
  input  logic        M1_ARVALID,
  output logic        M1_ARREADY,
  output logic [3:0]  M1_RID,
  output logic [31:0] M1_RDATA,
  output logic [1:0]  M1_RRESP,
  output logic        M1_RLAST,
  output logic        M1_RVALID,
  input  logic        M1_RREADY,
  // slave
  output logic [3:0]  S_ARID,
  output logic [31:0] S_ARADDR,
  output logic [3:0]  S_ARLEN,
  output logic [2:0]  S_ARSIZE,
  output logic [1:0]  S_ARBURST,
  output logic        S_ARVALID,
  input  logic        S_ARREADY,
  input  logic [3:0]  S_RID,
  input  logic [31:0] S_RDATA,
  input  logic [1:0]  S_RRESP,
  input  logic        S_RLAST,
  input  logic        S_RVALID,
  output logic        S_RREADY,
  output logic        len_err
);

  localparam int GW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [GW-1:0] grant, grant_nx;
  logic [GW-1:0] last_grant, last_grant_nx;
  logic [3:0]    beat_cnt, beat_cnt_nx;
  logic          len_err_nx;

  logic          sel_m1;
  logic          sel_arvalid;
  logic [3:0]    sel_arlen;
  logic          sel_rready;

  assign sel_m1      = (grant == GW'(1));
  assign sel_arvalid = sel_m1 ? M1_ARVALID : M0_ARVALID;
  assign sel_arlen   = sel_m1 ? M1_ARLEN   : M0_ARLEN;
  assign sel_rready  = sel_m1 ? M1_RREADY  : M0_RREADY;

  // Payload is muxed, not registered: masters hold it stable until ARREADY.
  assign S_ARID    = sel_m1 ? M1_ARID    : M0_ARID;
  assign S_ARADDR  = sel_m1 ? M1_ARADDR  : M0_ARADDR;
  assign S_ARLEN   = sel_arlen;
  assign S_ARSIZE  = sel_m1 ? M1_ARSIZE  : M0_ARSIZE;
  assign S_ARBURST = sel_m1 ? M1_ARBURST : M0_ARBURST;

  assign M0_RID   = S_RID;
  assign M0_RDATA = S_RDATA;
  assign M0_RRESP = S_RRESP;
  assign M0_RLAST = S_RLAST;
  assign M1_RID   = S_RID;
  assign M1_RDATA = S_RDATA;
  assign M1_RRESP = S_RRESP;
  assign M1_RLAST = S_RLAST;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state      <= IDLE;
      grant      <= GW'(0);
      last_grant <= GW'(LAST_GRANT_RST);
      beat_cnt   <= 4'd0;
      len_err    <= 1'b0;
    end else begin
      state      <= state_nx;
      grant      <= grant_nx;
      last_grant <= last_grant_nx;
      beat_cnt   <= beat_cnt_nx;
      len_err    <= len_err_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    grant_nx      = grant;
    last_grant_nx = last_grant;
    beat_cnt_nx   = beat_cnt;
    len_err_nx    = len_err;
    S_ARVALID     = 1'b0;
    M0_ARREADY    = 1'b0;
    M1_ARREADY    = 1'b0;
    S_RREADY      = 1'b0;
    M0_RVALID     = 1'b0;
    M1_RVALID     = 1'b0;

    case (state)
      IDLE: begin
        if (M0_ARVALID || M1_ARVALID) begin
          if (M0_ARVALID && M1_ARVALID)
            grant_nx = (last_grant == GW'(1)) ? GW'(0) : GW'(1);
          else
            grant_nx = M1_ARVALID ? GW'(1) : GW'(0);
          state_nx = ADDR;
        end
      end

      ADDR: begin
        S_ARVALID  = sel_arvalid;
        M0_ARREADY = !sel_m1 && S_ARREADY;
        M1_ARREADY = sel_m1 && S_ARREADY;
        if (sel_arvalid && S_ARREADY) begin
          beat_cnt_nx = sel_arlen;
          state_nx    = DATA;
        end
      end

      DATA: begin
        S_RREADY  = sel_rready;
        M0_RVALID = !sel_m1 && S_RVALID;
        M1_RVALID = sel_m1 && S_RVALID;
        if (S_RVALID && sel_rready) begin
          if (S_RLAST) begin
            state_nx      = IDLE;
            last_grant_nx = grant;
            if (beat_cnt != 4'd0)
              len_err_nx = 1'b1;
          end else if (beat_cnt == 4'd0) begin
            // Overlong burst: flag it, keep counting at zero until RLAST shows up.
            len_err_nx = 1'b1;
          end else begin
            beat_cnt_nx = beat_cnt - 4'd1;
          end
        end
      end

      default: state_nx = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_arbiter.sv
`default_nettype none
// Testbench for axi_rd_arbiter: vector table, directed corner sequences, randomized traffic vs. model.
module tb_axi_rd_arbiter;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [3:0]  M0_ARID, M1_ARID, S_ARID;
  logic [31:0] M0_ARADDR, M1_ARADDR, S_ARADDR;
  logic [3:0]  M0_ARLEN, M1_ARLEN, S_ARLEN;
  logic [2:0]  M0_ARSIZE, M1_ARSIZE, S_ARSIZE;
  logic [1:0]  M0_ARBURST, M1_ARBURST, S_ARBURST;
  logic        M0_ARVALID, M1_ARVALID, S_ARVALID;
  logic        M0_ARREADY, M1_ARREADY, S_ARREADY;
  logic [3:0]  M0_RID, M1_RID, S_RID;
  logic [31:0] M0_RDATA, M1_RDATA, S_RDATA;
  logic [1:0]  M0_RRESP, M1_RRESP, S_RRESP;
  logic        M0_RLAST, M1_RLAST, S_RLAST;
  logic        M0_RVALID, M1_RVALID, S_RVALID;
  logic        M0_RREADY, M1_RREADY, S_RREADY;
  logic        len_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 ACLK = ~ACLK;

  axi_rd_arbiter #(.NUM_M(2), .LAST_GRANT_RST(1'b1)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .M0_ARID(M0_ARID), .M0_ARADDR(M0_ARADDR), .M0_ARLEN(M0_ARLEN), .M0_ARSIZE(M0_ARSIZE),
    .M0_ARBURST(M0_ARBURST), .M0_ARVALID(M0_ARVALID), .M0_ARREADY(M0_ARREADY),
    .M0_RID(M0_RID), .M0_RDATA(M0_RDATA), .M0_RRESP(M0_RRESP), .M0_RLAST(M0_RLAST),
    .M0_RVALID(M0_RVALID), .M0_RREADY(M0_RREADY),
    .M1_ARID(M1_ARID), .M1_ARADDR(M1_ARADDR), .M1_ARLEN(M1_ARLEN), .M1_ARSIZE(M1_ARSIZE),
    .M1_ARBURST(M1_ARBURST), .M1_ARVALID(M1_ARVALID), .M1_ARREADY(M1_ARREADY),
    .M1_RID(M1_RID), .M1_RDATA(M1_RDATA), .M1_RRESP(M1_RRESP), .M1_RLAST(M1_RLAST),
    .M1_RVALID(M1_RVALID), .M1_RREADY(M1_RREADY),
    .S_ARID(S_ARID), .S_ARADDR(S_ARADDR), .S_ARLEN(S_ARLEN), .S_ARSIZE(S_ARSIZE),
    .S_ARBURST(S_ARBURST), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
    .S_RID(S_RID), .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RLAST(S_RLAST),
    .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
    .len_err(len_err)
  );

  // iv = {m0_arvalid, m1_arvalid, s_arready, s_rvalid, s_rlast, m0_rready, m1_rready}
  // ev = {s_arvalid, m0_arready, m1_arready, s_rready, m0_rvalid, m1_rvalid, len_err}
  typedef struct packed {
    logic [6:0]  iv;
    logic [6:0]  ev;
    logic [31:0] addr;
    logic [3:0]  len;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic nxt();
    @(posedge ACLK);
    #1;
  endtask

  task automatic zero_inputs();
    M0_ARVALID = 0; M1_ARVALID = 0; S_ARREADY = 0; S_RVALID = 0; S_RLAST = 0;
    M0_RREADY = 0; M1_RREADY = 0; S_RID = 0; S_RDATA = 0; S_RRESP = 0;
  endtask

  task automatic do_reset();
    zero_inputs();
    ARESETn = 0;
    repeat (2) @(posedge ACLK);
    #1 ARESETn = 1;
  endtask

  task automatic chk_all_quiet(input string nm);
    chk({nm, "_s_arvalid"}, S_ARVALID, 0);
    chk({nm, "_s_rready"}, S_RREADY, 0);
    chk({nm, "_m0_arready"}, M0_ARREADY, 0);
    chk({nm, "_m1_arready"}, M1_ARREADY, 0);
    chk({nm, "_m0_rvalid"}, M0_RVALID, 0);
    chk({nm, "_m1_rvalid"}, M1_RVALID, 0);
    chk({nm, "_len_err"}, len_err, 0);
  endtask

  // Random-phase state: master agents, slave agent, and the reference model.
  bit          req [2];
  logic [3:0]  pid [2];
  logic [31:0] paddr [2];
  logic [3:0]  plen [2];
  int          mph, own, prev, mlen, mk;
  bit          merr;
  int          s_left;
  bit          s_rv;
  logic [31:0] s_dat;
  logic [3:0]  s_id;
  logic [1:0]  s_resp;
  bit          e_sarv, e_ar0, e_ar1, e_srr, e_rv0, e_rv1, rr_own;
  int          delta;

  initial begin
    tbl[0]  = '{7'b1000000, 7'b0000000, 32'h0,   4'd0};
    tbl[1]  = '{7'b1000000, 7'b1000000, 32'h100, 4'd3};
    tbl[2]  = '{7'b1000000, 7'b1000000, 32'h100, 4'd3};
    tbl[3]  = '{7'b1010000, 7'b1100000, 32'h100, 4'd3};
    tbl[4]  = '{7'b0001010, 7'b0001100, 32'h0,   4'd0};
    tbl[5]  = '{7'b0001010, 7'b0001100, 32'h0,   4'd0};
    tbl[6]  = '{7'b0001010, 7'b0001100, 32'h0,   4'd0};
    tbl[7]  = '{7'b0001110, 7'b0001100, 32'h0,   4'd0};
    tbl[8]  = '{7'b0001000, 7'b0000000, 32'h0,   4'd0};
    tbl[9]  = '{7'b0101000, 7'b0000000, 32'h0,   4'd0};
    tbl[10] = '{7'b0111001, 7'b1010000, 32'h200, 4'd1};
    tbl[11] = '{7'b0001000, 7'b0000010, 32'h0,   4'd0};
    tbl[12] = '{7'b0001000, 7'b0000010, 32'h0,   4'd0};
    tbl[13] = '{7'b0001000, 7'b0000010, 32'h0,   4'd0};
    tbl[14] = '{7'b0001001, 7'b0001010, 32'h0,   4'd0};
    tbl[15] = '{7'b0001101, 7'b0001010, 32'h0,   4'd0};
    tbl[16] = '{7'b0000000, 7'b0000000, 32'h0,   4'd0};

    M0_ARID = 4'h3; M0_ARADDR = 32'h100; M0_ARLEN = 4'd3; M0_ARSIZE = 3'd2; M0_ARBURST = 2'd1;
    M1_ARID = 4'h5; M1_ARADDR = 32'h200; M1_ARLEN = 4'd1; M1_ARSIZE = 3'd2; M1_ARBURST = 2'd1;
    zero_inputs();
    ARESETn = 0;
    #2;
    chk_all_quiet("reset");
    repeat (2) @(posedge ACLK);
    #1 ARESETn = 1;

    // Single M0 burst, stray data in IDLE, then M1 burst with RREADY back-pressure.
    for (int i = 0; i < 17; i++) begin
      {M0_ARVALID, M1_ARVALID, S_ARREADY, S_RVALID, S_RLAST, M0_RREADY, M1_RREADY} = tbl[i].iv;
      S_RDATA = 32'hD000_0000 + i;
      S_RID   = 4'(i);
      @(negedge ACLK);
      chk($sformatf("tbl%0d_s_arvalid", i), S_ARVALID, tbl[i].ev[6]);
      chk($sformatf("tbl%0d_m0_arready", i), M0_ARREADY, tbl[i].ev[5]);
      chk($sformatf("tbl%0d_m1_arready", i), M1_ARREADY, tbl[i].ev[4]);
      chk($sformatf("tbl%0d_s_rready", i), S_RREADY, tbl[i].ev[3]);
      chk($sformatf("tbl%0d_m0_rvalid", i), M0_RVALID, tbl[i].ev[2]);
      chk($sformatf("tbl%0d_m1_rvalid", i), M1_RVALID, tbl[i].ev[1]);
      chk($sformatf("tbl%0d_len_err", i), len_err, tbl[i].ev[0]);
      if (tbl[i].ev[6]) begin
        chk($sformatf("tbl%0d_s_araddr", i), S_ARADDR, tbl[i].addr);
        chk($sformatf("tbl%0d_s_arlen", i), S_ARLEN, tbl[i].len);
      end
      if (tbl[i].ev[2]) chk($sformatf("tbl%0d_m0_rdata", i), M0_RDATA, 32'hD000_0000 + i);
      if (tbl[i].ev[1]) chk($sformatf("tbl%0d_m1_rdata", i), M1_RDATA, 32'hD000_0000 + i);
      nxt();
    end

    // Tie from reset: M0, M1, M0, M1 with one IDLE cycle between bursts.
    do_reset();
    M0_ARLEN = 0; M1_ARLEN = 0;
    M0_ARVALID = 1; M1_ARVALID = 1; S_ARREADY = 1;
    S_RVALID = 1; S_RLAST = 1; M0_RREADY = 1; M1_RREADY = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge ACLK);
      chk($sformatf("tie%0d_idle_s_arvalid", k), S_ARVALID, 0);
      chk($sformatf("tie%0d_idle_s_rready", k), S_RREADY, 0);
      nxt();
      @(negedge ACLK);
      chk($sformatf("tie%0d_m0_arready", k), M0_ARREADY, (k % 2) == 0);
      chk($sformatf("tie%0d_m1_arready", k), M1_ARREADY, (k % 2) == 1);
      chk($sformatf("tie%0d_s_araddr", k), S_ARADDR, ((k % 2) == 0) ? 32'h100 : 32'h200);
      nxt();
      @(negedge ACLK);
      chk($sformatf("tie%0d_m0_rvalid", k), M0_RVALID, (k % 2) == 0);
      chk($sformatf("tie%0d_m1_rvalid", k), M1_RVALID, (k % 2) == 1);
      chk($sformatf("tie%0d_s_rready", k), S_RREADY, 1);
      nxt();
    end

    // Early RLAST: ARLEN=2 but RLAST on beat 2.
    do_reset();
    M0_ARLEN = 2; M0_ARVALID = 1; S_ARREADY = 1; M0_RREADY = 1;
    nxt();
    nxt();
    M0_ARVALID = 0; S_RVALID = 1; S_RLAST = 0;
    nxt();
    S_RLAST = 1;
    @(negedge ACLK);
    chk("short_err_before", len_err, 0);
    nxt();
    @(negedge ACLK);
    chk("short_len_err", len_err, 1);
    chk("short_idle_s_rready", S_RREADY, 0);
    chk("short_idle_m0_rvalid", M0_RVALID, 0);

    // Overlong burst: ARLEN=0 with RLAST missing on beat 1.
    do_reset();
    chk("long_err_after_reset", len_err, 0);
    M0_ARLEN = 0; M0_ARVALID = 1; S_ARREADY = 1; M0_RREADY = 1;
    nxt();
    nxt();
    M0_ARVALID = 0; S_RVALID = 1; S_RLAST = 0;
    @(negedge ACLK);
    chk("long_err_before", len_err, 0);
    nxt();
    @(negedge ACLK);
    chk("long_len_err", len_err, 1);
    chk("long_still_data_rvalid", M0_RVALID, 1);
    chk("long_still_data_rready", S_RREADY, 1);
    nxt();
    S_RLAST = 1;
    nxt();
    @(negedge ACLK);
    chk("long_done_s_rready", S_RREADY, 0);
    chk("long_done_m0_rvalid", M0_RVALID, 0);

    // Reset mid-burst after beat 1 of ARLEN=7.
    do_reset();
    M0_ARLEN = 7; M0_ARVALID = 1; S_ARREADY = 1; M0_RREADY = 1;
    nxt();
    nxt();
    M0_ARVALID = 0; S_RVALID = 1; S_RLAST = 0;
    nxt();
    chk("midrst_pre_m0_rvalid", M0_RVALID, 1);
    #1 ARESETn = 0;
    #1;
    chk_all_quiet("midrst");
    repeat (2) @(posedge ACLK);
    #1 ARESETn = 1;
    zero_inputs();
    M0_ARLEN = 0; M1_ARLEN = 0; M0_ARVALID = 1; M1_ARVALID = 1; S_ARREADY = 1;
    nxt();
    @(negedge ACLK);
    chk("midrst_tie_m0_arready", M0_ARREADY, 1);
    chk("midrst_tie_m1_arready", M1_ARREADY, 0);
    chk("midrst_tie_s_araddr", S_ARADDR, 32'h100);

    // Randomized traffic against a transaction-level model.
    do_reset();
    mph = 0; own = 0; prev = 1; merr = 0; mlen = 0; mk = 0;
    req[0] = 0; req[1] = 0;
    s_left = 0; s_rv = 0; s_dat = 0; s_id = 0; s_resp = 0;
    for (int n = 0; n < 2; n++) begin
      pid[n] = 0; paddr[n] = 0; plen[n] = 0;
    end
    for (int c = 0; c < 4000; c++) begin
      M0_ARVALID = req[0]; M0_ARID = pid[0]; M0_ARADDR = paddr[0]; M0_ARLEN = plen[0];
      M1_ARVALID = req[1]; M1_ARID = pid[1]; M1_ARADDR = paddr[1]; M1_ARLEN = plen[1];
      S_ARREADY = 1'($urandom_range(0, 1));
      if (s_left > 0 && !s_rv && $urandom_range(0, 1) == 1) begin
        s_rv = 1; s_dat = $urandom; s_id = 4'($urandom); s_resp = 2'($urandom);
      end
      S_RVALID = s_rv; S_RDATA = s_dat; S_RID = s_id; S_RRESP = s_resp;
      S_RLAST = (s_left == 1);
      M0_RREADY = ($urandom_range(0, 3) != 0);
      M1_RREADY = ($urandom_range(0, 3) != 0);
      @(negedge ACLK);

      rr_own = (own == 0) ? M0_RREADY : M1_RREADY;
      e_sarv = (mph == 1) && req[own];
      e_ar0  = (mph == 1) && (own == 0) && S_ARREADY;
      e_ar1  = (mph == 1) && (own == 1) && S_ARREADY;
      e_srr  = (mph == 2) && rr_own;
      e_rv0  = (mph == 2) && (own == 0) && S_RVALID;
      e_rv1  = (mph == 2) && (own == 1) && S_RVALID;
      chk("rnd_s_arvalid", S_ARVALID, e_sarv);
      chk("rnd_m0_arready", M0_ARREADY, e_ar0);
      chk("rnd_m1_arready", M1_ARREADY, e_ar1);
      chk("rnd_s_rready", S_RREADY, e_srr);
      chk("rnd_m0_rvalid", M0_RVALID, e_rv0);
      chk("rnd_m1_rvalid", M1_RVALID, e_rv1);
      chk("rnd_len_err", len_err, merr);
      if (e_sarv) begin
        chk("rnd_s_araddr", S_ARADDR, paddr[own]);
        chk("rnd_s_arid", S_ARID, pid[own]);
        chk("rnd_s_arlen", S_ARLEN, plen[own]);
      end
      if (e_rv0) begin
        chk("rnd_m0_rdata", M0_RDATA, s_dat);
        chk("rnd_m0_rid", M0_RID, s_id);
        chk("rnd_m0_rresp", M0_RRESP, s_resp);
      end
      if (e_rv1) begin
        chk("rnd_m1_rdata", M1_RDATA, s_dat);
        chk("rnd_m1_rid", M1_RID, s_id);
        chk("rnd_m1_rresp", M1_RRESP, s_resp);
      end

      if (e_sarv && S_ARREADY) begin
        req[own] = 0;
        mlen = int'(plen[own]);
        mk = 0;
        mph = 2;
        delta = 0;
        case ($urandom_range(0, 7))
          0: delta = 1;
          1: delta = (mlen > 0) ? -1 : 0;
          default: delta = 0;
        endcase
        s_left = mlen + 1 + delta;
      end else if (mph == 2 && S_RVALID && rr_own) begin
        mk++;
        s_left--;
        s_rv = 0;
        if (S_RLAST) begin
          if (mk != mlen + 1) merr = 1;
          mph = 0;
          prev = own;
        end else if (mk >= mlen + 1) begin
          merr = 1;
        end
      end else if (mph == 0 && (req[0] || req[1])) begin
        own = (req[0] && req[1]) ? 1 - prev : (req[0] ? 0 : 1);
        mph = 1;
      end

      for (int n = 0; n < 2; n++) begin
        if (!req[n] && $urandom_range(0, 2) == 0) begin
          req[n] = 1;
          pid[n] = 4'($urandom);
          paddr[n] = $urandom;
          plen[n] = 4'($urandom_range(0, 3));
        end
      end
      nxt();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
